// File: rtl/cv32e40x_pkg.sv
// rtl/cv32e40x_pkg.sv - shared types for the cv32e40x write-back stage
//
// Purpose: register-file address type, EX/WB pipeline register layout and the
// write-back FSM state encoding used by cv32e40x_wb_stage.

package cv32e40x_pkg;

  typedef logic [4:0] rf_addr_t;

  // EX/WB pipeline register as presented to the write-back stage
  typedef struct packed {
    logic        instr_valid;
    logic        rf_we;
    rf_addr_t    rf_waddr;
    logic [31:0] rf_wdata;
    logic        data_req;
    logic        illegal_insn;
    logic        ebrk_insn;
    logic        ecall_insn;
  } ex_wb_pipe_t;

  typedef enum logic [1:0] {
    WB_IDLE      = 2'd0,
    WB_WAIT_RESP = 2'd1,
    WB_DRAIN     = 2'd2
  } wb_state_e;

endpackage

// File: rtl/cv32e40x_wb_stage.sv
// rtl/cv32e40x_wb_stage.sv - write-back stage with load-response tracking
//
// Purpose: retires one instruction per cycle from the EX/WB pipeline register,
// writes the register file (also the ID forwarding path), waits for LSU load
// data and discards responses owed to killed loads.
//
// Optional feature macro: CV32E40X_WB_RETIRE_CNT_EN enables the retired
// instruction counter; without it retire_cnt_o is tied to zero.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   ex_wb_pipe_i    EX/WB pipeline register
//   kill_wb_i       flush of the instruction in WB
//   lsu_rvalid_i    LSU load response valid (single-cycle pulse)
//   lsu_rdata_i     LSU load data
//   lsu_err_i       LSU bus error, qualified by lsu_rvalid_i
//   rf_we_wb_o      register file write enable
//   rf_waddr_wb_o   register file write address
//   rf_wdata_wb_o   register file write data / ID forwarding value
//   wb_ready_o      WB accepts a new instruction from EX next cycle
//   wb_valid_o      instruction retires this cycle
//   lsu_err_wb_o    load bus error reported to the controller
//   retire_cnt_o    retired-instruction count

module cv32e40x_wb_stage
  import cv32e40x_pkg::*;
#(
  parameter int RETIRE_CNT_W = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  ex_wb_pipe_t             ex_wb_pipe_i,
  input  logic                    kill_wb_i,
  input  logic                    lsu_rvalid_i,
  input  logic [31:0]             lsu_rdata_i,
  input  logic                    lsu_err_i,
  output logic                    rf_we_wb_o,
  output rf_addr_t                rf_waddr_wb_o,
  output logic [31:0]             rf_wdata_wb_o,
  output logic                    wb_ready_o,
  output logic                    wb_valid_o,
  output logic                    lsu_err_wb_o,
  output logic [RETIRE_CNT_W-1:0] retire_cnt_o
);

  wb_state_e state_q, state_d;
  logic      exc;
  logic      load_in_wb;
  logic      alu_in_wb;

  assign exc        = ex_wb_pipe_i.illegal_insn | ex_wb_pipe_i.ebrk_insn | ex_wb_pipe_i.ecall_insn;
  assign load_in_wb = ex_wb_pipe_i.instr_valid & ex_wb_pipe_i.data_req;
  assign alu_in_wb  = ex_wb_pipe_i.instr_valid & ~ex_wb_pipe_i.data_req;

  // Address is never gated; only rf_we qualifies the write
  assign rf_waddr_wb_o = ex_wb_pipe_i.rf_waddr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rf_we_wb_o    = 1'b0;
    rf_wdata_wb_o = ex_wb_pipe_i.rf_wdata;
    wb_ready_o    = 1'b1;
    wb_valid_o    = 1'b0;
    lsu_err_wb_o  = 1'b0;

    case (state_q)
      WB_DRAIN: begin
        // A killed load still owes a response; swallow it before accepting
        // anything new so it cannot be mistaken for a later load's data.
        wb_ready_o = 1'b0;
        if (lsu_rvalid_i) begin
          state_d = WB_IDLE;
        end
      end

      default: begin
        // IDLE and WAIT_RESP share the same datapath: the load stays in WB
        // (held by wb_ready_o=0) until its response arrives.
        if (load_in_wb) begin
          wb_ready_o = lsu_rvalid_i;
          if (lsu_rvalid_i) begin
            state_d       = WB_IDLE;
            rf_wdata_wb_o = lsu_rdata_i;
            if (!kill_wb_i) begin
              if (lsu_err_i) begin
                lsu_err_wb_o = 1'b1;
              end else begin
                rf_we_wb_o = 1'b1;
                wb_valid_o = 1'b1;
              end
            end
          end else begin
            state_d = kill_wb_i ? WB_DRAIN : WB_WAIT_RESP;
          end
        end else begin
          state_d = WB_IDLE;
          if (alu_in_wb && !kill_wb_i) begin
            rf_we_wb_o = ex_wb_pipe_i.rf_we & ~exc;
            wb_valid_o = 1'b1;
          end
        end
      end
    endcase
  end

`ifdef CV32E40X_WB_RETIRE_CNT_EN
  logic [RETIRE_CNT_W-1:0] retire_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt_q <= '0;
    end else if (wb_valid_o) begin
      retire_cnt_q <= retire_cnt_q + RETIRE_CNT_W'(1);
    end
  end

  assign retire_cnt_o = retire_cnt_q;
`else
  assign retire_cnt_o = '0;
`endif

`ifndef SYNTHESIS
  // A response with no load in WB and none owed means the LSU broke protocol
  a_no_spurious_rvalid : assert property (
    @(posedge clk) disable iff (!rst_n)
    !((state_q == WB_IDLE) && lsu_rvalid_i && !load_in_wb)
  );
`endif

endmodule
